hit_scanner: RTL and testbench

Frame-synchronous collision detector that consumes the sprite PIO exports of the Nios system (bullets, monsters, Kraid, Kraid projectiles, Samus) and returns per-object hit flags for software to read back through a PIO input. Once per frame, on the falling edge of VGA vertical sync, it snapshots all coordinates and enable bits, then tests one object pair per clock with a small FSM. Results are held until software acknowledges them.

---
 rtl/hit_scanner.sv | 218 +++++++++++++++++++++
 tb/tb_hit_scanner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hit_scanner.sv
// Frame-synchronous sprite collision scanner: snapshots positions on vsync fall, tests one pair per clock.
// Optional macro HIT_SAMUS_EN adds the Samus-vs-hazard pairs and drives samus_hit.
module hit_scanner #(
  parameter int BULLET_W  = 8,
  parameter int MONSTER_W = 16,
  parameter int KRAID_W   = 32,
  parameter int KRAID_H   = 48,
  parameter int PROJ_W    = 8,
  parameter int SAMUS_W   = 16,
  parameter int SAMUS_H   = 32
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       vs,
  input  logic       bullet1_en,  input logic [9:0] bullet1_x,  input logic [9:0] bullet1_y,
  input  logic       bullet2_en,  input logic [9:0] bullet2_x,  input logic [9:0] bullet2_y,
  input  logic       bullet3_en,  input logic [9:0] bullet3_x,  input logic [9:0] bullet3_y,
  input  logic       monster1_en, input logic [9:0] monster1_x, input logic [9:0] monster1_y,
  input  logic       monster2_en, input logic [9:0] monster2_x, input logic [9:0] monster2_y,
  input  logic       monster3_en, input logic [9:0] monster3_x, input logic [9:0] monster3_y,
  input  logic       kraid_en,    input logic [9:0] kraid_x,    input logic [9:0] kraid_y,
  input  logic       kraid_spike_en, input logic [9:0] kraid_spike_x, input logic [9:0] kraid_spike_y,
  input  logic       kraid_throw_en, input logic [9:0] kraid_throw_x, input logic [9:0] kraid_throw_y,
  input  logic       samus_en,    input logic [9:0] samus_x,    input logic [9:0] samus_y,
  input  logic       hit_ack,
  output logic [2:0] bullet_hit,
  output logic [3:0] target_hit,
  output logic       samus_hit,
  output logic       hit_valid,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SNAP, SCAN, DONE} state_t;

`ifdef HIT_SAMUS_EN
  localparam logic [4:0] LAST_P = 5'd17;
`else
  localparam logic [4:0] LAST_P = 5'd11;
`endif

  // Object slots: 0-2 bullets, 3-5 monsters, 6 Kraid, 7 spike, 8 throw, 9 Samus
  localparam int N_OBJ = 10;

  state_t                  state_r, state_s;
  logic                    vs_q_r;
  logic [4:0]              p_r;
  logic [N_OBJ-1:0][9:0]   x_r, y_r, in_x_s, in_y_s;
  logic [N_OBJ-1:0]        en_r, in_en_s;
  logic [2:0]              bullet_acc_r, bullet_hit_r;
  logic [3:0]              target_acc_r, target_hit_r;
  logic                    samus_hit_r, hit_valid_r, overrun_r, busy_r;
  logic [3:0]              a_idx_s, b_idx_s;
  logic                    hit_s;
`ifdef HIT_SAMUS_EN
  logic                    samus_acc_r;
`endif

  assign in_en_s = {samus_en, kraid_throw_en, kraid_spike_en, kraid_en, monster3_en, monster2_en,
                    monster1_en, bullet3_en, bullet2_en, bullet1_en};
  assign in_x_s  = {samus_x, kraid_throw_x, kraid_spike_x, kraid_x, monster3_x, monster2_x,
                    monster1_x, bullet3_x, bullet2_x, bullet1_x};
  assign in_y_s  = {samus_y, kraid_throw_y, kraid_spike_y, kraid_y, monster3_y, monster2_y,
                    monster1_y, bullet3_y, bullet2_y, bullet1_y};

  function automatic logic [10:0] obj_w(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: obj_w = 11'(BULLET_W);
      4'd3, 4'd4, 4'd5: obj_w = 11'(MONSTER_W);
      4'd6:             obj_w = 11'(KRAID_W);
      4'd7, 4'd8:       obj_w = 11'(PROJ_W);
      4'd9:             obj_w = 11'(SAMUS_W);
      default:          obj_w = 11'd0;
    endcase
  endfunction

  function automatic logic [10:0] obj_h(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: obj_h = 11'(BULLET_W);
      4'd3, 4'd4, 4'd5: obj_h = 11'(MONSTER_W);
      4'd6:             obj_h = 11'(KRAID_H);
      4'd7, 4'd8:       obj_h = 11'(PROJ_W);
      4'd9:             obj_h = 11'(SAMUS_H);
      default:          obj_h = 11'd0;
    endcase
  endfunction

  // Sums are 11 bits wide so boxes near x/y=1023 compare without wrapping
  function automatic logic overlap(input logic [9:0] ax, input logic [9:0] ay,
                                   input logic [10:0] aw, input logic [10:0] ah,
                                   input logic [9:0] bx, input logic [9:0] by,
                                   input logic [10:0] bw, input logic [10:0] bh);
    overlap = ({1'b0, ax} < ({1'b0, bx} + bw)) && ({1'b0, bx} < ({1'b0, ax} + aw)) &&
              ({1'b0, ay} < ({1'b0, by} + bh)) && ({1'b0, by} < ({1'b0, ay} + ah));
  endfunction

  // Pair decode: p<12 is bullet p/4 vs target p%4, beyond that Samus vs each hazard
  always_comb begin
    a_idx_s = 4'd0;
    b_idx_s = 4'd3;
    if (p_r < 5'd12) begin
      a_idx_s = {2'b00, p_r[3:2]};
      b_idx_s = (p_r[1:0] == 2'd3) ? 4'd6 : (4'd3 + {2'b00, p_r[1:0]});
    end else begin
      a_idx_s = 4'd9;
      case (p_r)
        5'd12:   b_idx_s = 4'd3;
        5'd13:   b_idx_s = 4'd4;
        5'd14:   b_idx_s = 4'd5;
        5'd15:   b_idx_s = 4'd6;
        5'd16:   b_idx_s = 4'd7;
        5'd17:   b_idx_s = 4'd8;
        default: b_idx_s = 4'd3;
      endcase
    end
    hit_s = en_r[a_idx_s] && en_r[b_idx_s] &&
            overlap(x_r[a_idx_s], y_r[a_idx_s], obj_w(a_idx_s), obj_h(a_idx_s),
                    x_r[b_idx_s], y_r[b_idx_s], obj_w(b_idx_s), obj_h(b_idx_s));
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (vs_q_r && !vs) state_s = SNAP;
        else               state_s = IDLE;
      end
      SNAP: state_s = SCAN;
      SCAN: begin
        if (p_r == LAST_P) state_s = DONE;
        else               state_s = SCAN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, vsync history, pair counter and busy flag
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r <= IDLE;
      vs_q_r  <= 1'b1;
      p_r     <= 5'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      vs_q_r  <= vs;
      busy_r  <= (state_s != IDLE);
      if (state_r == SNAP)      p_r <= 5'd0;
      else if (state_r == SCAN) p_r <= p_r + 5'd1;
    end
  end

  // Snapshot bank and hit accumulators
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      x_r          <= '0;
      y_r          <= '0;
      en_r         <= '0;
      bullet_acc_r <= 3'd0;
      target_acc_r <= 4'd0;
`ifdef HIT_SAMUS_EN
      samus_acc_r  <= 1'b0;
`endif
    end else if (state_r == SNAP) begin
      x_r          <= in_x_s;
      y_r          <= in_y_s;
      en_r         <= in_en_s;
      bullet_acc_r <= 3'd0;
      target_acc_r <= 4'd0;
`ifdef HIT_SAMUS_EN
      samus_acc_r  <= 1'b0;
`endif
    end else if (state_r == SCAN && hit_s) begin
      if (p_r < 5'd12) begin
        bullet_acc_r <= bullet_acc_r | (3'b001 << p_r[3:2]);
        target_acc_r <= target_acc_r | (4'b0001 << p_r[1:0]);
      end else begin
`ifdef HIT_SAMUS_EN
        samus_acc_r  <= 1'b1;
`endif
      end
    end
  end

  // Result registers; a DONE in the same cycle as hit_ack keeps hit_valid set
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bullet_hit_r <= 3'd0;
      target_hit_r <= 4'd0;
      samus_hit_r  <= 1'b0;
      hit_valid_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (state_r == DONE) begin
      bullet_hit_r <= bullet_acc_r;
      target_hit_r <= target_acc_r;
`ifdef HIT_SAMUS_EN
      samus_hit_r  <= samus_acc_r;
`else
      samus_hit_r  <= 1'b0;
`endif
      hit_valid_r  <= 1'b1;
      overrun_r    <= hit_valid_r | (overrun_r & ~hit_ack);
    end else if (hit_ack) begin
      hit_valid_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end
  end

  assign bullet_hit = bullet_hit_r;
  assign target_hit = target_hit_r;
  assign samus_hit  = samus_hit_r;
  assign hit_valid  = hit_valid_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_hit_scanner.sv
// Scoreboard bench for hit_scanner: driver queues hand-computed frame results, monitor checks them.
module tb_hit_scanner;

`ifdef HIT_SAMUS_EN
  localparam logic SAMUS = 1'b1;
  localparam int   LAT   = 20;
`else
  localparam logic SAMUS = 1'b0;
  localparam int   LAT   = 14;
`endif

  logic clk_clk = 1'b0;
  logic reset_reset_n, vs, hit_ack;
  logic [9:0] en_v;
  logic [9:0] xv [10];
  logic [9:0] yv [10];
  logic [2:0] bullet_hit;
  logic [3:0] target_hit;
  logic samus_hit, hit_valid, overrun, busy;

  always #5 clk_clk = ~clk_clk;

  hit_scanner dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .vs(vs),
    .bullet1_en(en_v[0]), .bullet1_x(xv[0]), .bullet1_y(yv[0]),
    .bullet2_en(en_v[1]), .bullet2_x(xv[1]), .bullet2_y(yv[1]),
    .bullet3_en(en_v[2]), .bullet3_x(xv[2]), .bullet3_y(yv[2]),
    .monster1_en(en_v[3]), .monster1_x(xv[3]), .monster1_y(yv[3]),
    .monster2_en(en_v[4]), .monster2_x(xv[4]), .monster2_y(yv[4]),
    .monster3_en(en_v[5]), .monster3_x(xv[5]), .monster3_y(yv[5]),
    .kraid_en(en_v[6]), .kraid_x(xv[6]), .kraid_y(yv[6]),
    .kraid_spike_en(en_v[7]), .kraid_spike_x(xv[7]), .kraid_spike_y(yv[7]),
    .kraid_throw_en(en_v[8]), .kraid_throw_x(xv[8]), .kraid_throw_y(yv[8]),
    .samus_en(en_v[9]), .samus_x(xv[9]), .samus_y(yv[9]),
    .hit_ack(hit_ack),
    .bullet_hit(bullet_hit), .target_hit(target_hit), .samus_hit(samus_hit),
    .hit_valid(hit_valid), .overrun(overrun), .busy(busy)
  );

  typedef struct {
    int         cyc;
    logic [2:0] b;
    logic [3:0] t;
    logic       s;
    logic       ov;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t cur;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: a result is presented when busy drops out of reset
  always @(negedge clk_clk) begin
    if (reset_reset_n && busy_prev && !busy) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        cur = sb_q.pop_front();
        chk("latency", cyc, cur.cyc);
        chk("bullet_hit", int'(bullet_hit), int'(cur.b));
        chk("target_hit", int'(target_hit), int'(cur.t));
        chk("samus_hit", int'(samus_hit), int'(cur.s));
        chk("hit_valid", int'(hit_valid), 1);
        chk("overrun", int'(overrun), int'(cur.ov));
      end
    end
    busy_prev <= busy;
  end

  task automatic clear_all();
    for (int i = 0; i < 10; i++) begin
      en_v[i] = 1'b0;
      xv[i]   = 10'd0;
      yv[i]   = 10'd0;
    end
  endtask

  task automatic set_obj(input int idx, input logic [9:0] x, input logic [9:0] y);
    en_v[idx] = 1'b1;
    xv[idx]   = x;
    yv[idx]   = y;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60) begin
      @(negedge clk_clk);
      k++;
    end
    if (busy) chk("busy_timeout", 1, 0);
    @(negedge clk_clk);
  endtask

  task automatic frame(input logic [2:0] eb, input logic [3:0] et, input logic es,
                       input logic eov, input bit change_after, input bit vs_again,
                       input bit ack_done);
    int e;
    sb_item_t x;
    @(negedge clk_clk);
    vs = 1'b0;
    e = cyc + 1;
    x.cyc = e + LAT; x.b = eb; x.t = et; x.s = es; x.ov = eov;
    sb_q.push_back(x);
    @(negedge clk_clk);
    vs = 1'b1;
    if (change_after) begin
      @(negedge clk_clk);
      clear_all();
    end
    if (vs_again) begin
      @(negedge clk_clk); vs = 1'b0;
      @(negedge clk_clk); vs = 1'b1;
    end
    if (ack_done) begin
      while (cyc < e + LAT - 1) @(negedge clk_clk);
      hit_ack = 1'b1;
      @(negedge clk_clk);
      hit_ack = 1'b0;
    end
    wait_idle();
  endtask

  task automatic ack();
    @(negedge clk_clk); hit_ack = 1'b1;
    @(negedge clk_clk); hit_ack = 1'b0;
    chk("ack_hit_valid", int'(hit_valid), 0);
    chk("ack_overrun", int'(overrun), 0);
  endtask

  task automatic cfg_basic(input logic m3_en);
    clear_all();
    set_obj(1, 10'd100, 10'd100);
    set_obj(5, 10'd105, 10'd104);
    en_v[5] = m3_en;
  endtask

  initial begin
    int e;
    reset_reset_n = 1'b0; vs = 1'b1; hit_ack = 1'b0;
    clear_all();
    repeat (3) @(negedge clk_clk);
    chk("rst_bullet_hit", int'(bullet_hit), 0);
    chk("rst_target_hit", int'(target_hit), 0);
    chk("rst_hit_valid", int'(hit_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);
    reset_reset_n = 1'b1;

    // Basic hit left unacknowledged, then reset mid-scan
    cfg_basic(1'b1);
    frame(3'b010, 4'b0100, 1'b0, 1'b0, 0, 0, 0);
    @(negedge clk_clk); vs = 1'b0; e = cyc + 1;
    @(negedge clk_clk); vs = 1'b1;
    while (cyc < e + 7) @(negedge clk_clk);
    chk("pre_reset_busy", int'(busy), 1);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("midrst_bullet_hit", int'(bullet_hit), 0);
    chk("midrst_target_hit", int'(target_hit), 0);
    chk("midrst_hit_valid", int'(hit_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk_clk); #2 reset_reset_n = 1'b1;

    frame(3'b010, 4'b0100, 1'b0, 1'b0, 0, 0, 0); ack();
    cfg_basic(1'b0);
    frame(3'b000, 4'b0000, 1'b0, 1'b0, 0, 0, 0); ack();

    // Horizontal adjacency: touching edges do not overlap
    clear_all(); set_obj(0, 10'd100, 10'd50); set_obj(3, 10'd108, 10'd50);
    frame(3'b000, 4'b0000, 1'b0, 1'b0, 0, 0, 0); ack();
    xv[3] = 10'd107;
    frame(3'b001, 4'b0001, 1'b0, 1'b0, 0, 0, 0); ack();

    // Kraid near the right edge of the 10-bit range
    clear_all(); set_obj(6, 10'd1010, 10'd100); set_obj(2, 10'd1020, 10'd110);
    frame(3'b100, 4'b1000, 1'b0, 1'b0, 0, 0, 0); ack();

    clear_all(); set_obj(9, 10'd200, 10'd300); set_obj(8, 10'd210, 10'd320);
    frame(3'b000, 4'b0000, SAMUS, 1'b0, 0, 0, 0); ack();

    // Two bullets on monster2 with Samus overlapping it; no ack, then overrun
    clear_all();
    set_obj(0, 10'd300, 10'd300); set_obj(2, 10'd310, 10'd310);
    set_obj(4, 10'd305, 10'd305); set_obj(9, 10'd290, 10'd290);
    frame(3'b101, 4'b0010, SAMUS, 1'b0, 0, 0, 0);
    cfg_basic(1'b1);
    frame(3'b010, 4'b0100, 1'b0, 1'b1, 0, 0, 0); ack();

    // Inputs removed after the snapshot must not change the result
    cfg_basic(1'b1);
    frame(3'b010, 4'b0100, 1'b0, 1'b0, 1, 0, 0); ack();

    // A second vsync edge during the scan is ignored
    cfg_basic(1'b0);
    frame(3'b000, 4'b0000, 1'b0, 1'b0, 0, 1, 0); ack();

    // Ack coincident with DONE: hit_valid must remain set
    cfg_basic(1'b1);
    frame(3'b010, 4'b0100, 1'b0, 1'b0, 0, 0, 1); ack();

    repeat (5) @(negedge clk_clk);
    chk("queue_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
